// File: rtl/conv_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// conv_pkg: shared event types, sizes and helpers for the Convolution2d input path.
// Revision: 1.0
// ----------------------------------------------------------------------------
package conv_pkg;

    localparam int DEFAULT_BITS_PER_COORDINATE_IN = 5;
    localparam int DEFAULT_IN_CHANNELS            = 4;
    localparam int DEFAULT_IMG_WIDTH              = 20;
    localparam int DEFAULT_IMG_HEIGHT             = 16;
    localparam int DEFAULT_EVENT_FIFO_DEPTH       = 16;

    typedef struct packed {
        logic [DEFAULT_BITS_PER_COORDINATE_IN-1:0] x;
        logic [DEFAULT_BITS_PER_COORDINATE_IN-1:0] y;
    } vec2_t;

    typedef logic [DEFAULT_IN_CHANNELS-1:0] spike_vector_in_t;

    typedef struct packed {
        vec2_t            coord;
        spike_vector_in_t spikes;
    } input_vector_t;

    typedef enum logic [1:0] {
        OCC_EMPTY  = 2'd0,
        OCC_ACTIVE = 2'd1,
        OCC_FULL   = 2'd2
    } occ_state_t;

    // Image bounds default to the package geometry; callers with other sizes pass them in.
    function automatic logic event_in_range(
        input logic [DEFAULT_BITS_PER_COORDINATE_IN-1:0] x,
        input logic [DEFAULT_BITS_PER_COORDINATE_IN-1:0] y,
        input int width  = DEFAULT_IMG_WIDTH,
        input int height = DEFAULT_IMG_HEIGHT
    );
        return (32'(x) < width) && (32'(y) < height);
    endfunction

endpackage
`default_nettype wire

// File: rtl/event_fifo_mem.sv
`default_nettype none
// ----------------------------------------------------------------------------
// event_fifo_mem: event storage, synchronous write, asynchronous head and tail reads.
// Tail read port exists only with EVENT_COALESCE_EN. Revision: 1.0
// ----------------------------------------------------------------------------
module event_fifo_mem
    import conv_pkg::*;
#(
    parameter int DEPTH     = DEFAULT_EVENT_FIFO_DEPTH,
    parameter int ADDR_BITS = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 wr_en,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  input_vector_t        wr_data,
    input  logic [ADDR_BITS-1:0] rd_addr,
`ifdef EVENT_COALESCE_EN
    input  logic [ADDR_BITS-1:0] tail_addr,
    output input_vector_t        tail_data,
`endif
    output input_vector_t        rd_data
);

    // No reset: stale contents are never visible because occupancy gates the output.
    input_vector_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

`ifdef EVENT_COALESCE_EN
    assign tail_data = mem[tail_addr];
`endif

endmodule
`default_nettype wire

// File: rtl/event_capture_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// event_capture_fifo: filters spike events and queues them show-ahead for Convolution2d.
// EVENT_COALESCE_EN: OR same-(x,y) events into the tail entry. Revision: 1.0
// ----------------------------------------------------------------------------
module event_capture_fifo
    import conv_pkg::*;
#(
    parameter int COORD_BITS  = DEFAULT_BITS_PER_COORDINATE_IN,
    parameter int IN_CHANNELS = DEFAULT_IN_CHANNELS,
    parameter int IMG_WIDTH   = DEFAULT_IMG_WIDTH,
    parameter int IMG_HEIGHT  = DEFAULT_IMG_HEIGHT,
    parameter int FIFO_DEPTH  = DEFAULT_EVENT_FIFO_DEPTH,
    parameter int CNT_BITS    = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [COORD_BITS-1:0]         in_x,
    input  logic [COORD_BITS-1:0]         in_y,
    input  logic [IN_CHANNELS-1:0]        in_spikes,
    output input_vector_t                 event_out,
    output logic                          event_valid,
    input  logic                          event_ack,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          fifo_full,
    output logic                          fifo_empty,
    output logic [CNT_BITS-1:0]           drop_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    occ_state_t    state;
    occ_state_t    state_next;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] wr_ptr_next;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] rd_ptr_next;
    logic [AW-1:0] wr_addr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic [CNT_BITS-1:0] drop_next;
    logic          ready_en;
    logic          accept;
    logic          keep;
    logic          drop;
    logic          pop;
    logic          push;
    logic          merge;
    logic          wr_en;
    input_vector_t new_event;
    input_vector_t wr_data;
    input_vector_t rd_data;

    // ready_en holds in_ready low through reset and releases it on the first cycle after.
    assign in_ready    = ready_en && (state != OCC_FULL);
    assign event_valid = (state != OCC_EMPTY);
    assign fifo_full   = (state == OCC_FULL);
    assign fifo_empty  = (state == OCC_EMPTY);
    assign fifo_count  = count;
    assign event_out   = event_valid ? rd_data : '0;

    assign new_event = {in_x, in_y, in_spikes};
    assign accept    = in_valid && in_ready;
    assign keep      = accept && (in_spikes != '0) && event_in_range(in_x, in_y, IMG_WIDTH, IMG_HEIGHT);
    assign drop      = accept && !keep;
    assign pop       = event_ack && event_valid;

`ifdef EVENT_COALESCE_EN
    input_vector_t tail_data;
    input_vector_t merged_event;
    logic [AW-1:0] tail_ptr;

    // count>=2 keeps the tail distinct from the head the consumer may be holding.
    assign tail_ptr     = wr_ptr - 1'b1;
    assign merged_event = {tail_data.coord, tail_data.spikes | in_spikes};
    assign merge        = keep && (count >= CW'(2)) && !pop && (tail_data.coord == new_event.coord);
    assign wr_addr      = merge ? tail_ptr : wr_ptr;
    assign wr_data      = merge ? merged_event : new_event;
`else
    assign merge   = 1'b0;
    assign wr_addr = wr_ptr;
    assign wr_data = new_event;
`endif

    assign push  = keep && !merge;
    assign wr_en = push || merge;

    event_fifo_mem #(
        .DEPTH     (FIFO_DEPTH),
        .ADDR_BITS (AW)
    ) u_mem (
        .clk       (clk),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_addr   (rd_ptr),
`ifdef EVENT_COALESCE_EN
        .tail_addr (tail_ptr),
        .tail_data (tail_data),
`endif
        .rd_data   (rd_data)
    );

    always_comb begin
        state_next  = state;
        wr_ptr_next = wr_ptr;
        rd_ptr_next = rd_ptr;
        count_next  = count;
        drop_next   = drop_count;

        if (push) begin
            wr_ptr_next = wr_ptr + 1'b1;
        end
        if (pop) begin
            rd_ptr_next = rd_ptr + 1'b1;
        end

        case ({push, pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase

        if (drop && (drop_count != '1)) begin
            drop_next = drop_count + 1'b1;
        end

        case (state)
            OCC_EMPTY: begin
                if (push) begin
                    state_next = OCC_ACTIVE;
                end
            end
            OCC_ACTIVE: begin
                if (count_next == CW'(FIFO_DEPTH)) begin
                    state_next = OCC_FULL;
                end else if (count_next == '0) begin
                    state_next = OCC_EMPTY;
                end
            end
            OCC_FULL: begin
                if (pop) begin
                    state_next = OCC_ACTIVE;
                end
            end
            default: state_next = OCC_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= OCC_EMPTY;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            drop_count <= '0;
            ready_en   <= 1'b0;
        end else begin
            state      <= state_next;
            wr_ptr     <= wr_ptr_next;
            rd_ptr     <= rd_ptr_next;
            count      <= count_next;
            drop_count <= drop_next;
            ready_en   <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_event_capture_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_event_capture_fifo: directed and random stimulus against a queue reference model.
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_event_capture_fifo;
    import conv_pkg::*;

    localparam int W        = DEFAULT_IMG_WIDTH;
    localparam int H        = DEFAULT_IMG_HEIGHT;
    localparam int D        = 16;
    localparam int CB       = 4;
    localparam int DROP_MAX = (1 << CB) - 1;
    localparam int PAD      = 32 - $bits(input_vector_t);
`ifdef EVENT_COALESCE_EN
    localparam int         COAL_COUNT = 2;
    localparam logic [3:0] COAL_TAIL  = 4'b0011;
`else
    localparam int         COAL_COUNT = 3;
    localparam logic [3:0] COAL_TAIL  = 4'b0001;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          event_ack = 1'b0;
    logic [4:0]    in_x = '0;
    logic [4:0]    in_y = '0;
    logic [3:0]    in_spikes = '0;
    logic          in_ready;
    input_vector_t event_out;
    logic          event_valid;
    logic [4:0]    fifo_count;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CB-1:0] drop_count;

    int            n_checks = 0;
    int            n_fail = 0;
    input_vector_t exp_q[$];
    int            exp_drop = 0;
    bit            exp_ready_en = 1'b0;

    event_capture_fifo #(
        .FIFO_DEPTH (D),
        .CNT_BITS   (CB)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_x        (in_x),
        .in_y        (in_y),
        .in_spikes   (in_spikes),
        .event_out   (event_out),
        .event_valid (event_valid),
        .event_ack   (event_ack),
        .fifo_count  (fifo_count),
        .fifo_full   (fifo_full),
        .fifo_empty  (fifo_empty),
        .drop_count  (drop_count)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ev32(input int x, input int y, input int s);
        input_vector_t e;
        e = {5'(x), 5'(y), 4'(s)};
        return {{PAD{1'b0}}, e};
    endfunction

    // Reference model: a plain queue of pending events, updated at each rising edge.
    task automatic model_step();
        int            n;
        bit            acc;
        bit            pop;
        bit            merged;
        input_vector_t ev;
        input_vector_t tail;
        if (!rst_n) begin
            exp_q.delete();
            exp_drop     = 0;
            exp_ready_en = 1'b0;
            return;
        end
        n      = exp_q.size();
        acc    = in_valid && exp_ready_en && (n < D);
        pop    = event_ack && (n > 0);
        merged = 1'b0;
        if (acc) begin
            if (in_spikes == 4'd0 || int'(in_x) >= W || int'(in_y) >= H) begin
                if (exp_drop < DROP_MAX) exp_drop++;
            end else begin
                ev = {in_x, in_y, in_spikes};
`ifdef EVENT_COALESCE_EN
                if (n >= 2 && !pop && exp_q[n-1].coord == ev.coord) begin
                    tail        = exp_q[n-1];
                    tail.spikes = tail.spikes | ev.spikes;
                    exp_q[n-1]  = tail;
                    merged      = 1'b1;
                end
`endif
                if (!merged) exp_q.push_back(ev);
            end
        end
        if (pop) void'(exp_q.pop_front());
        exp_ready_en = 1'b1;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Monitor: compare every visible output against the model once per cycle.
    initial forever begin
        int          n;
        logic [31:0] exp_head;
        @(negedge clk);
        n        = exp_q.size();
        exp_head = (n > 0) ? {{PAD{1'b0}}, exp_q[0]} : 32'd0;
        check("in_ready",    32'(in_ready),    32'(exp_ready_en && n < D));
        check("event_valid", 32'(event_valid), 32'(n > 0));
        check("fifo_empty",  32'(fifo_empty),  32'(n == 0));
        check("fifo_full",   32'(fifo_full),   32'(n == D));
        check("fifo_count",  32'(fifo_count),  32'(n));
        check("drop_count",  32'(drop_count),  32'(exp_drop));
        check("event_out",   {{PAD{1'b0}}, event_out}, exp_head);
    end

    task automatic drive(input bit v, input int x, input int y, input int s, input bit ack);
        @(negedge clk);
        in_valid  = v;
        in_x      = 5'(x);
        in_y      = 5'(y);
        in_spikes = 4'(s);
        event_ack = ack;
    endtask

    // Present an event and hold it until in_ready; the next rising edge accepts it.
    task automatic send(input int x, input int y, input int s, input bit ack);
        drive(1'b1, x, y, s, ack);
        for (int k = 0; k < 64 && !in_ready; k++) @(negedge clk);
        check("send_timeout", 32'(in_ready), 32'd1);
    endtask

    task automatic idle(input int n, input bit ack);
        repeat (n) drive(1'b0, 0, 0, 0, ack);
    endtask

    initial begin
        bit ready_prev;
        int ackp;

        repeat (3) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_valid", 32'(event_valid), 32'd0);
        check("rst_event_out", {{PAD{1'b0}}, event_out}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", 32'(in_ready), 32'd1);

        // Single event latency and pop
        send(3, 4, 5, 1'b0);
        drive(1'b0, 0, 0, 0, 1'b1);
        check("single_valid", 32'(event_valid), 32'd1);
        check("single_data", {{PAD{1'b0}}, event_out}, ev32(3, 4, 5));
        drive(1'b0, 0, 0, 0, 1'b0);
        check("single_empty", 32'(fifo_empty), 32'd1);

        // Filtering
        send(3, 4, 0, 1'b0);
        send(W, 1, 1, 1'b0);
        send(1, H, 1, 1'b0);
        idle(1, 1'b0);
        check("filter_drop", 32'(drop_count), 32'd3);
        check("filter_empty", 32'(fifo_empty), 32'd1);

        // Fill, backpressure, one pop, wrap
        for (int i = 0; i < 16; i++) send(i, i, 1 + (i % 15), 1'b0);
        drive(1'b1, 17, 2, 9, 1'b0);
        check("full_flag", 32'(fifo_full), 32'd1);
        check("full_ready", 32'(in_ready), 32'd0);
        drive(1'b1, 17, 2, 9, 1'b0);
        drive(1'b1, 17, 2, 9, 1'b1);
        drive(1'b1, 17, 2, 9, 1'b0);
        check("after_pop_ready", 32'(in_ready), 32'd1);
        check("after_pop_count", 32'(fifo_count), 32'd15);
        drive(1'b0, 0, 0, 0, 1'b0);
        check("refill_count", 32'(fifo_count), 32'd16);
        idle(17, 1'b1);
        idle(1, 1'b0);
        check("drain_empty", 32'(fifo_empty), 32'd1);

        // Concurrent push and pop at count 5
        for (int i = 0; i < 5; i++) send(i, 3, 1, 1'b0);
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, i, 7, 2 + (i % 13), 1'b1);
            check("concurrent_count", 32'(fifo_count), 32'd5);
        end
        idle(5, 1'b1);
        idle(1, 1'b0);
        check("concurrent_empty", 32'(fifo_empty), 32'd1);

        // Reset with 7 stored events
        for (int i = 0; i < 7; i++) send(i, i, 1, 1'b0);
        idle(1, 1'b0);
        check("pre_reset_count", 32'(fifo_count), 32'd7);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("mid_reset_count", 32'(fifo_count), 32'd0);
        check("mid_reset_valid", 32'(event_valid), 32'd0);
        check("mid_reset_drop", 32'(drop_count), 32'd0);
        check("mid_reset_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        check("post_reset_ready", 32'(in_ready), 32'd1);

        // Same-coordinate event behind a two-entry queue
        send(5, 5, 1, 1'b0);
        send(1, 1, 1, 1'b0);
        send(1, 1, 2, 1'b0);
        idle(1, 1'b0);
        check("coalesce_count", 32'(fifo_count), 32'(COAL_COUNT));
        idle(1, 1'b1);
        idle(1, 1'b0);
        check("coalesce_tail", {{PAD{1'b0}}, event_out}, ev32(1, 1, int'(COAL_TAIL)));
        idle(3, 1'b1);
        idle(1, 1'b0);
        check("coalesce_empty", 32'(fifo_empty), 32'd1);

        // Random traffic; the source holds an event until it is accepted
        ready_prev = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            ackp = ((c / 500) % 2 == 1) ? 80 : 30;
            @(negedge clk);
            if (!in_valid || ready_prev) begin
                in_valid  = ($urandom_range(0, 99) < 60);
                in_x      = ($urandom_range(0, 9) < 7) ? 5'($urandom_range(0, 2)) : 5'($urandom_range(0, 23));
                in_y      = ($urandom_range(0, 9) < 7) ? 5'($urandom_range(0, 2)) : 5'($urandom_range(0, 19));
                in_spikes = 4'($urandom_range(0, 15));
            end
            event_ack  = ($urandom_range(0, 99) < ackp);
            ready_prev = in_ready;
        end
        idle(20, 1'b1);
        idle(1, 1'b0);
        check("final_empty", 32'(fifo_empty), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/event_capture_fifo.md
Name: event_capture_fifo

Overview:
- Upstream stage of Convolution2d. Replaces its temporary event_in/event_valid/event_ack hookup.
- Accepts spike events (x, y, per-channel spike vector) from the input event source through a valid/ready handshake.
- Filters events that would cause no work or are out of range.
- Buffers events in a show-ahead FIFO and presents the head to the convolution, holding it stable until acknowledged.

Parameters:
- COORD_BITS, DEFAULT_BITS_PER_COORDINATE_IN: bits per x/y coordinate.
- IN_CHANNELS, DEFAULT_IN_CHANNELS: spike vector width.
- IMG_WIDTH, DEFAULT_IMG_WIDTH: valid x range is 0..IMG_WIDTH-1.
- IMG_HEIGHT, DEFAULT_IMG_HEIGHT: valid y range is 0..IMG_HEIGHT-1.
- FIFO_DEPTH, 16: entry count; power of 2, at least 2.
- CNT_BITS, 16: width of the drop counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  source event valid
- in_ready  out  1  block can accept an event
- in_x  in  COORD_BITS  event x coordinate
- in_y  in  COORD_BITS  event y coordinate
- in_spikes  in  IN_CHANNELS  per-channel spike flags
- event_out  out  input_vector_t  head event {x, y, spikes}, to Convolution2d event_in
- event_valid  out  1  head valid
- event_ack  in  1  consumer acknowledge; pops the head
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current occupancy
- fifo_full  out  1  occupancy == FIFO_DEPTH
- fifo_empty  out  1  occupancy == 0
- drop_count  out  CNT_BITS  saturating count of filtered events

Behaviour:
- Clocking and reset:
  - One clock (clk). Reset is synchronous, active-low (rst_n).
  - Reset clears wr_ptr, rd_ptr, count and drop_count.
  - Reset values: in_ready=0 during reset and 1 in the first cycle after reset; event_valid=0; fifo_empty=1; fifo_full=0; fifo_count=0; drop_count=0; event_out=0.
  - Reset mid-operation discards all stored events; the storage array is not cleared.
- Occupancy states, derived from count:
  - EMPTY (count=0) -> ACTIVE on push.
  - ACTIVE -> FULL when count reaches FIFO_DEPTH.
  - ACTIVE -> EMPTY on a pop at count=1 with no push.
  - FULL -> ACTIVE on a pop.
- Input handshake:
  - in_ready = !fifo_full. It is registered-state only and never depends on event_ack in the same cycle.
  - An event is accepted when in_valid && in_ready at a rising edge.
  - The source must hold the event while in_valid=1 and in_ready=0.
- Filtering:
  - An accepted event is consumed but not stored when spikes==0, x>=IMG_WIDTH, or y>=IMG_HEIGHT.
  - A filtered event increments drop_count, saturating at 2^CNT_BITS-1.
  - Otherwise the event is pushed at wr_ptr.
- Output side:
  - event_valid = !fifo_empty. event_out = entry at rd_ptr.
  - event_out is combinational from storage and must remain stable while event_valid=1 until the ack cycle.
  - Latency: a push into an empty FIFO at edge N gives event_valid=1 in the cycle after edge N.
- Pop:
  - A pop occurs at an edge where event_ack && event_valid. The next head appears the following cycle.
  - event_ack while event_valid=0 is ignored.
  - Expected use: Convolution2d asserts event_ack once per event, in its prepare cycle.
- Simultaneous push and pop:
  - When 0<count<FIFO_DEPTH: count is unchanged and both pointers advance.
  - When full: a pop occurs and no push occurs (in_ready was 0).
  - When empty: a push occurs and the ack is ignored.
- Pointers: log2(FIFO_DEPTH) bits, wrapping modulo FIFO_DEPTH. count is tracked separately to distinguish full from empty.

Optional Feature:
- Macro: EVENT_COALESCE_EN.
- Defined:
  - Applies to an accepted, unfiltered event when count>=2 and no pop occurs this cycle.
  - If that event's (x, y) equals the tail entry's (x, y), its spikes are OR-ed into the tail entry. There is no push and count is unchanged.
  - The head entry is never modified, because the consumer may already have sampled it.
  - in_ready is unchanged (still !fifo_full).
- Not defined: every unfiltered accepted event is pushed as a separate entry.

Decomposition:
- conv_pkg: reuse vec2_t, spike_vector_in_t and input_vector_t.
- conv_pkg additions:
  - constant DEFAULT_EVENT_FIFO_DEPTH=16.
  - function event_in_range(x, y), which returns the in-bounds check.
- Sub-module event_fifo_mem: simple dual-port storage array with a synchronous write, an asynchronous read at rd_ptr, and a tail read-modify-write port used for coalescing.

Test Plan:
- Single event (3,4,spikes=4'b0101) into an empty FIFO -> event_valid=1 one cycle later, event_out={3,4,0101}; ack -> empty.
- Push 16 events with no ack -> fifo_full=1, in_ready=0; a 17th event is held by the source. One ack -> next-cycle in_ready=1 and the 17th event is accepted; FIFO order is preserved across pointer wrap.
- Events with spikes=0, x=IMG_WIDTH, and y=IMG_HEIGHT -> none stored, drop_count=3, fifo_empty stays 1.
- Concurrent push and pop at count=5 for 20 cycles -> count stays 5; the output sequence equals the input sequence.
- Assert rst_n=0 for one cycle at count=7 -> next cycle count=0, event_valid=0, drop_count=0.
- With EVENT_COALESCE_EN, at count=2 with tail (1,1,0001), push (1,1,0010) -> count stays 2 and the tail becomes 0011. Without the macro -> count=3.
